timer_dev: RTL and testbench



---
 rtl/timer_dev.sv | 129 ++++++++++++
 tb/tb_timer_dev.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
// timer_dev: bus-programmable 32-bit down-counter with a level interrupt.
// Optional macro TIMER_BE_EN: CTRL/PRESET writes honour the byte enables.
module timer_dev #(
  parameter logic [31:0] PRESET_RST = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_t;

  state_t      r_state;
  logic        r_en;
  logic [1:0]  r_mode;
  logic        r_im;
  logic        r_pend;
  logic [31:0] r_preset;
  logic [31:0] r_count;

  logic [31:0] w_mask;
  logic        w_hit;
  logic        w_wr_ctrl;
  logic        w_wr_pre;
  logic        w_clr;
  logic        w_en_wr;
  logic [3:0]  w_ctrl;
  logic [3:0]  w_ctrl_nxt;

`ifdef TIMER_BE_EN
  assign w_mask = {{8{be[3]}}, {8{be[2]}},
                   {8{be[1]}}, {8{be[0]}}};
  assign w_hit  = |be;
`else
  logic w_be_unused;
  assign w_be_unused = ^be;
  assign w_mask = '1;
  assign w_hit  = 1'b1;
`endif

  assign w_wr_ctrl  = we && (addr == 2'd0);
  assign w_wr_pre   = we && (addr == 2'd1);
  assign w_clr      = (w_wr_ctrl || w_wr_pre) && w_hit;
  assign w_ctrl     = {r_im, r_mode, r_en};
  assign w_ctrl_nxt = (w_ctrl & ~w_mask[3:0])
                    | (din[3:0] & w_mask[3:0]);
  // a CTRL write that touches EN overrides the one-shot EN clear
  assign w_en_wr    = w_wr_ctrl && w_mask[0];

  assign irq = r_pend & r_im;

  always_comb begin
    dout = '0;
    unique case (addr)
      2'd0:    dout = {28'd0, w_ctrl};
      2'd1:    dout = r_preset;
      2'd2:    dout = r_count;
      default: dout = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_en     <= 1'b0;
      r_mode   <= 2'b00;
      r_im     <= 1'b0;
      r_pend   <= 1'b0;
      r_preset <= PRESET_RST;
      r_count  <= '0;
    end else begin
      if (w_wr_pre)
        r_preset <= (r_preset & ~w_mask)
                  | (din & w_mask);
      if (w_wr_ctrl)
        {r_im, r_mode, r_en} <= w_ctrl_nxt;
      if (w_clr)
        r_pend <= 1'b0;

      // later assignments below win, so a pend set beats a write clear
      unique case (r_state)
        S_IDLE: begin
          if (r_en)
            r_state <= S_LOAD;
        end
        S_LOAD: begin
          if (r_en) begin
            r_count <= r_preset;
            r_state <= S_CNT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CNT: begin
          if (!r_en) begin
            r_state <= S_IDLE;
          end else if (r_count == 32'd0) begin
            r_state <= S_INT;
            r_pend  <= 1'b1;
          end else begin
            r_count <= r_count - 32'd1;
          end
        end
        S_INT: begin
          if (r_mode == 2'b01) begin
            r_pend  <= 1'b0;
            r_state <= S_LOAD;
          end else begin
            if (!w_en_wr)
              r_en <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: scenario tasks for timer_dev, checked
// against latency formulas and a register readback model.
module tb_timer_dev;

  localparam logic [31:0] PR = 32'hCAFE_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'hF;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        irq;

  int pass = 0;
  int total = 0;
  int cyc = 0;

  timer_dev #(.PRESET_RST(PR)) dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .we   (we),
    .be   (be),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic to_e(input int t);
    while (cyc < t) adv(1);
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [31:0] d,
                    input logic [3:0] b);
    addr = a;
    din  = d;
    be   = b;
    we   = 1'b1;
    adv(1);
    we   = 1'b0;
    be   = 4'hF;
  endtask

  task automatic rd(input logic [1:0] a,
                    output logic [31:0] d);
    addr = a;
    #1;
    d = dout;
  endtask

  task automatic do_reset();
    we  = 1'b0;
    rst = 1'b1;
    adv(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    for (int a = 0; a < 4; a++) begin
      logic [31:0] ex;
      ex = (a == 1) ? PR : 32'd0;
      rd(a[1:0], v);
      total++;
      if (v !== ex)
        $display("FAIL reset_reg%0d got=%h exp=%h",
                 a, v, ex);
      else pass++;
    end
    total++;
    if (irq !== 1'b0)
      $display("FAIL reset_irq got=%b exp=0", irq);
    else pass++;
  endtask

  task automatic test_oneshot(input int n);
    logic [31:0] v;
    do_reset();
    wr(2'd1, n, 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    cyc = 0;
    to_e(2);
    rd(2'd2, v);
    total++;
    if (v !== n)
      $display("FAIL os_count_e2 got=%0d exp=%0d", v, n);
    else pass++;
    to_e(2 + n);
    rd(2'd2, v);
    total++;
    if (v !== 0 || irq !== 1'b0)
      $display("FAIL os_zero got=%0d/%b exp=0/0",
               v, irq);
    else pass++;
    to_e(3 + n);
    total++;
    if (irq !== 1'b1)
      $display("FAIL os_irq_rise got=%b exp=1", irq);
    else pass++;
    to_e(4 + n);
    rd(2'd0, v);
    total++;
    if (v !== 32'h8)
      $display("FAIL os_ctrl got=%h exp=8", v);
    else pass++;
    to_e(9 + n);
    rd(2'd2, v);
    total++;
    if (irq !== 1'b1 || v !== 0)
      $display("FAIL os_hold got=%b/%0d exp=1/0",
               irq, v);
    else pass++;
    wr(2'd0, 32'h0, 4'hF);
    total++;
    if (irq !== 1'b0)
      $display("FAIL os_clear got=%b exp=0", irq);
    else pass++;
  endtask

  task automatic test_autoreload(input int n);
    logic [31:0] v;
    int p;
    logic ex;
    p = n + 3;
    do_reset();
    wr(2'd1, n, 4'hF);
    wr(2'd0, 32'hB, 4'hF);
    cyc = 0;
    for (int k = 1; k <= 3 * p + 2; k++) begin
      to_e(k);
      ex = (k >= p) && ((k % p) == 0);
      total++;
      if (irq !== ex)
        $display("FAIL ar_irq n=%0d e%0d got=%b exp=%b",
                 n, k, irq, ex);
      else pass++;
      if (k > p && (k % p) == 2) begin
        rd(2'd2, v);
        total++;
        if (v !== n)
          $display("FAIL ar_reload e%0d got=%0d exp=%0d",
                   k, v, n);
        else pass++;
      end
    end
  endtask

  task automatic test_mask();
    do_reset();
    wr(2'd1, 32'd2, 4'hF);
    wr(2'd0, 32'h1, 4'hF);
    cyc = 0;
    for (int k = 1; k <= 8; k++) begin
      to_e(k);
      total++;
      if (irq !== 1'b0)
        $display("FAIL mask_irq e%0d got=%b exp=0",
                 k, irq);
      else pass++;
    end
    wr(2'd0, 32'h8, 4'hF);
    adv(2);
    total++;
    if (irq !== 1'b0)
      $display("FAIL mask_unmask got=%b exp=0", irq);
    else pass++;
  endtask

  task automatic test_pause(input int n);
    logic [31:0] v;
    do_reset();
    wr(2'd1, n, 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    cyc = 0;
    to_e(n - 2);
    rd(2'd2, v);
    total++;
    if (v !== 4)
      $display("FAIL pause_pre got=%0d exp=4", v);
    else pass++;
    wr(2'd0, 32'h8, 4'hF);
    adv(5);
    rd(2'd2, v);
    total++;
    if (v !== 3 || irq !== 1'b0)
      $display("FAIL pause_hold got=%0d/%b exp=3/0",
               v, irq);
    else pass++;
    wr(2'd0, 32'h9, 4'hF);
    cyc = 0;
    to_e(2);
    rd(2'd2, v);
    total++;
    if (v !== n)
      $display("FAIL pause_reload got=%0d exp=%0d",
               v, n);
    else pass++;
  endtask

  task automatic test_preset0();
    do_reset();
    wr(2'd1, 32'd0, 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    cyc = 0;
    to_e(2);
    total++;
    if (irq !== 1'b0)
      $display("FAIL p0_early got=%b exp=0", irq);
    else pass++;
    to_e(3);
    total++;
    if (irq !== 1'b1)
      $display("FAIL p0_irq got=%b exp=1", irq);
    else pass++;
  endtask

  task automatic test_preset_change();
    logic [31:0] v;
    do_reset();
    wr(2'd1, 32'd5, 4'hF);
    wr(2'd0, 32'hB, 4'hF);
    cyc = 0;
    to_e(4);
    wr(2'd1, 32'd9, 4'hF);
    rd(2'd2, v);
    total++;
    if (v !== 2)
      $display("FAIL pc_run got=%0d exp=2", v);
    else pass++;
    to_e(8);
    total++;
    if (irq !== 1'b1)
      $display("FAIL pc_first got=%b exp=1", irq);
    else pass++;
    to_e(10);
    rd(2'd2, v);
    total++;
    if (v !== 9)
      $display("FAIL pc_reload got=%0d exp=9", v);
    else pass++;
    to_e(19);
    total++;
    if (irq !== 1'b0)
      $display("FAIL pc_early got=%b exp=0", irq);
    else pass++;
    to_e(20);
    total++;
    if (irq !== 1'b1)
      $display("FAIL pc_second got=%b exp=1", irq);
    else pass++;
  endtask

  task automatic test_ctrl_at_int(input int n);
    logic [31:0] v;
    do_reset();
    wr(2'd1, n, 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    cyc = 0;
    to_e(3 + n);
    wr(2'd0, 32'h9, 4'hF);
    rd(2'd0, v);
    total++;
    if (v !== 32'h9 || irq !== 1'b0)
      $display("FAIL ci_ctrl got=%h/%b exp=9/0",
               v, irq);
    else pass++;
    to_e(6 + n);
    rd(2'd2, v);
    total++;
    if (v !== n)
      $display("FAIL ci_reload got=%0d exp=%0d", v, n);
    else pass++;
  endtask

  task automatic test_rst_int(input int n);
    logic [31:0] v;
    logic [31:0] c;
    do_reset();
    wr(2'd1, n, 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    cyc = 0;
    to_e(3 + n);
    total++;
    if (irq !== 1'b1)
      $display("FAIL ri_pre got=%b exp=1", irq);
    else pass++;
    rst = 1'b1;
    adv(1);
    rst = 1'b0;
    rd(2'd1, v);
    rd(2'd0, c);
    total++;
    if (irq !== 1'b0 || v !== PR || c !== 0)
      $display("FAIL ri_regs got=%b/%h/%h exp=0/%h/0",
               irq, v, c, PR);
    else pass++;
    adv(n + 5);
    rd(2'd2, v);
    total++;
    if (irq !== 1'b0 || v !== 0)
      $display("FAIL ri_idle got=%b/%0d exp=0/0",
               irq, v);
    else pass++;
  endtask

  task automatic test_be();
    logic [31:0] v;
    logic [31:0] ex_p;
    logic [31:0] ex_c;
`ifdef TIMER_BE_EN
    ex_p = 32'h0000_CCDD;
    ex_c = 32'h0;
`else
    ex_p = 32'hAABB_CCDD;
    ex_c = 32'h8;
`endif
    do_reset();
    wr(2'd1, 32'h0, 4'hF);
    wr(2'd1, 32'hAABB_CCDD, 4'b0011);
    rd(2'd1, v);
    total++;
    if (v !== ex_p)
      $display("FAIL be_preset got=%h exp=%h", v, ex_p);
    else pass++;
    wr(2'd0, 32'h8, 4'b0000);
    rd(2'd0, v);
    total++;
    if (v !== ex_c)
      $display("FAIL be_ctrl got=%h exp=%h", v, ex_c);
    else pass++;
  endtask

  task automatic test_random_regs();
    logic [3:0]  m_ctrl;
    logic [31:0] m_pre;
    logic [31:0] v;
    logic [31:0] d;
    logic [1:0]  a;
    do_reset();
    m_ctrl = 4'h0;
    m_pre  = PR;
    for (int i = 0; i < 24; i++) begin
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd0) d[0] = 1'b0;
      wr(a, d, 4'hF);
      if (a == 2'd0) m_ctrl = d[3:0];
      if (a == 2'd1) m_pre = d;
      rd(2'd0, v);
      total++;
      if (v !== {28'd0, m_ctrl})
        $display("FAIL rnd_ctrl i%0d got=%h exp=%h",
                 i, v, m_ctrl);
      else pass++;
      rd(2'd1, v);
      total++;
      if (v !== m_pre)
        $display("FAIL rnd_pre i%0d got=%h exp=%h",
                 i, v, m_pre);
      else pass++;
      rd(2'd2, v);
      rd(2'd3, d);
      total++;
      if (v !== 0 || d !== 0)
        $display("FAIL rnd_ro i%0d got=%h/%h exp=0/0",
                 i, v, d);
      else pass++;
    end
  endtask

  initial begin
    test_reset();
    test_oneshot(5);
    test_oneshot($urandom_range(1, 12));
    test_autoreload(3);
    test_autoreload($urandom_range(0, 6));
    test_mask();
    test_pause(7);
    test_pause($urandom_range(6, 20));
    test_preset0();
    test_preset_change();
    test_ctrl_at_int($urandom_range(1, 6));
    test_rst_int($urandom_range(0, 6));
    test_be();
    test_random_regs();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
